icache_refill_unit: RTL and testbench
=====================================

Name: icache_refill_unit

Overview:
- Lower-memory responder for the L1 instruction cache miss interface of fetch stage 1.
- Accepts a miss request (`miss`/`missAddr`), fetches the aligned block from the next memory level in fixed-width beats, and assembles it into one line.
- Returns the line through a one-cycle write strobe (`wrEnable`/`wrAddr`/`instBlock`).
- Sits between FetchStage1's L1ICache and the L2/memory port.

Parameters:
- `SIZE_PC`, 32, width of instruction and memory addresses.
- `CACHE_WIDTH`, 256, refill line width in bits (4 instructions × 64 bits).
- `BEAT_WIDTH`, 64, memory read data width per beat; `CACHE_WIDTH` must be a multiple of it.
- `OFFSET_BITS`, 5, byte-offset bits of a line (32-byte line, matching PC+32 sequential fetch).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `miss_i`  in  1  L1 instruction cache miss, level-held by the cache until filled.
- `missAddr_i`  in  `SIZE_PC`  missing fetch address, any byte alignment.
- `wrEnable_o`  out  1  one-cycle line write strobe to the L1 cache.
- `wrAddr_o`  out  `SIZE_PC`  line-aligned address of the written line.
- `instBlock_o`  out  `CACHE_WIDTH`  assembled line.
- `memReq_o`  out  1  read request to next level.
- `memAddr_o`  out  `SIZE_PC`  line-aligned request address.
- `memReqAck_i`  in  1  next level accepts request (handshake completes when `memReq_o` and `memReqAck_i` are both 1).
- `memRdValid_i`  in  1  read beat valid.
- `memRdData_i`  in  `BEAT_WIDTH`  read beat data.
- `busy_o`  out  1  refill in progress (state ≠ IDLE).

Behaviour:
- Reset (async): state = IDLE, beat counter = 0, all outputs 0, line buffer cleared to 0.
- Line address: `missAddr_i` with the low `OFFSET_BITS` bits forced to 0. It is captured in IDLE on the cycle `miss_i` = 1 and held until IDLE is re-entered. Later changes to `missAddr_i` are ignored.
- IDLE: if `miss_i` = 1, capture the line address and go to REQ. Otherwise stay.
- REQ:
  - `memReq_o` = 1 and `memAddr_o` = captured address.
  - Stay until `memReqAck_i` = 1, then go to RECV with beat counter = 0.
  - `memReq_o` drops the cycle after acceptance.
- RECV:
  - Each cycle `memRdValid_i` = 1 writes `memRdData_i` into line bits `[cnt*BEAT_WIDTH +: BEAT_WIDTH]` and increments the counter.
  - Beats arrive in ascending address order; gaps with `memRdValid_i` = 0 are allowed.
  - When the beat numbered `CACHE_WIDTH/BEAT_WIDTH - 1` is accepted, go to WRITE.
  - `memRdValid_i` outside RECV is ignored.
- WRITE: `wrEnable_o` = 1 for exactly one cycle; `wrAddr_o` = captured address; `instBlock_o` = assembled line. Next state is SETTLE.
- SETTLE: one idle cycle with `miss_i` ignored, so a stale miss from the cache's registered lookup is not re-requested. Then go to IDLE.
- Latency: `miss_i` sampled at cycle 0 → `memReq_o` at cycle 1. With ack at cycle 1 and back-to-back beats at cycles 2–5, `wrEnable_o` is at cycle 6.
- `wrAddr_o` and `instBlock_o` hold their last values when `wrEnable_o` = 0.
- Only one outstanding refill at a time. A miss that deasserts mid-refill (fetch redirect) does not abort; the fill completes and is written anyway.
- Reset asserted mid-REQ or mid-RECV returns immediately to IDLE with `memReq_o` = 0. A beat in flight is discarded.
- Beat counter width: `clog2(CACHE_WIDTH/BEAT_WIDTH)`; it wraps to 0 on entering WRITE.

Optional Feature:
- Macro: `ICACHE_REFILL_PREFETCH_EN`.
- When defined:
  - After SETTLE, if `miss_i` = 0, issue a next-line prefetch to (captured address + 2^`OFFSET_BITS`). The address wraps modulo 2^`SIZE_PC`.
  - The prefetch uses the same REQ/RECV handshake and stores into a one-entry prefetch buffer (address, line, valid). Nothing is written to the cache.
  - A later miss whose line address equals the buffered address with valid = 1 goes IDLE → WRITE directly, with no memory request. The buffer is invalidated on that use and on reset.
  - A non-matching miss arriving during a prefetch waits for the prefetch to finish, then is serviced normally.
- When undefined: no prefetch buffer; SETTLE → IDLE always.

Test Plan:
- Reset, then `miss_i` = 1 with `missAddr_i` = 0x0000_1234 → `memReq_o` = 1 with `memAddr_o` = 0x0000_1220. Ack immediately; beats 0x11…, 0x22…, 0x33…, 0x44… → `wrEnable_o` pulse one cycle, `wrAddr_o` = 0x0000_1220, `instBlock_o[63:0]` = beat 0 and `[255:192]` = beat 3; SETTLE ignores the still-high `miss_i`.
- Ack delayed 5 cycles and beats separated by 2 idle cycles → `memReq_o` held 5 cycles; `wrEnable_o` occurs only after the 4th beat; no early write.
- `miss_i` deasserted and `missAddr_i` changed to 0x0000_9000 during RECV → write still occurs to 0x0000_1220; no second request.
- Reset asserted during RECV after 2 beats → outputs 0 asynchronously, state IDLE; a new miss to 0x40 fetches a fresh 4 beats from `memAddr_o` = 0x40.
- `memRdValid_i` pulsed while IDLE → ignored; no `wrEnable_o`, counter stays 0.
- With `ICACHE_REFILL_PREFETCH_EN`: fill 0x1220, then prefetch request to 0x1240. A subsequent miss at 0x1248 → `wrEnable_o` within 2 cycles with no `memReq_o`. A miss at 0xFFFF_FFE0 → prefetch address wraps to 0x0000_0000.

Source files
------------

// File: rtl/icache_refill_unit.sv
// ---------------------------------------------------------------------------
// icache_refill_unit
//
// Purpose:
//   Lower-memory responder for the L1 instruction cache miss interface of
//   fetch stage 1. A miss request is turned into one line-aligned read
//   request to the next memory level. The returned beats are assembled into
//   a full cache line, and the line is handed back to the L1 cache through a
//   one-cycle write strobe.
//
// Optional feature (compile-time macro ICACHE_REFILL_PREFETCH_EN):
//   When the macro is defined, the unit issues a next-line prefetch after
//   each demand fill, but only if the cache has stopped missing. The
//   prefetched line is held in a one-entry buffer. A later miss that matches
//   the buffered line is answered directly, with no memory request. When the
//   macro is undefined, none of this logic exists and SETTLE always returns
//   to IDLE.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-high reset
//   miss_i        in   L1 miss, held by the cache until the line is written
//   missAddr_i    in   missing fetch address (any byte alignment)
//   wrEnable_o    out  one-cycle line write strobe to the L1 cache
//   wrAddr_o      out  line-aligned address of the written line (held)
//   instBlock_o   out  assembled line (held)
//   memReq_o      out  read request to the next level
//   memAddr_o     out  line-aligned request address
//   memReqAck_i   in   request accepted (handshake is memReq_o & memReqAck_i)
//   memRdValid_i  in   read beat valid
//   memRdData_i   in   read beat data
//   busy_o        out  refill in progress (state != IDLE)
// ---------------------------------------------------------------------------
module icache_refill_unit #(
  parameter int SIZE_PC     = 32,
  parameter int CACHE_WIDTH = 256,
  parameter int BEAT_WIDTH  = 64,   // CACHE_WIDTH must be a multiple of this
  parameter int OFFSET_BITS = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   miss_i,
  input  logic [SIZE_PC-1:0]     missAddr_i,
  output logic                   wrEnable_o,
  output logic [SIZE_PC-1:0]     wrAddr_o,
  output logic [CACHE_WIDTH-1:0] instBlock_o,
  output logic                   memReq_o,
  output logic [SIZE_PC-1:0]     memAddr_o,
  input  logic                   memReqAck_i,
  input  logic                   memRdValid_i,
  input  logic [BEAT_WIDTH-1:0]  memRdData_i,
  output logic                   busy_o
);

  localparam int BEATS = CACHE_WIDTH / BEAT_WIDTH;
  // Keep the counter at least one bit wide so the single-beat case
  // still elaborates.
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [SIZE_PC-1:0] LINE_MASK = {SIZE_PC{1'b1}} << OFFSET_BITS;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_RECV   = 3'd2,
    S_WRITE  = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  state_t                 state_reg;
  state_t                 state_next;
  logic [CNT_W-1:0]       cnt_reg;
  logic [SIZE_PC-1:0]     addr_reg;      // line currently being requested
  logic [CACHE_WIDTH-1:0] line_reg;      // beat assembly buffer
  logic [CACHE_WIDTH-1:0] line_next;     // line_reg with this cycle's beat merged
  logic [SIZE_PC-1:0]     wr_addr_reg;   // held write-port address
  logic [CACHE_WIDTH-1:0] wr_block_reg;  // held write-port data

  logic [SIZE_PC-1:0]     miss_line;
  logic                   capture;       // IDLE sees a miss this cycle
  logic                   beat_fire;     // beat accepted this cycle
  logic                   last_beat;     // final beat of the line accepted
  logic                   pf_hit;        // miss can be served from the prefetch buffer
  logic                   pf_fill;       // current REQ/RECV is a prefetch
  logic                   pf_launch;     // SETTLE starts a prefetch

  assign miss_line = missAddr_i & LINE_MASK;

  // -------------------------------------------------------------------------
  // Prefetch buffer. This block exists only when the feature is compiled in.
  // -------------------------------------------------------------------------
`ifdef ICACHE_REFILL_PREFETCH_EN
  localparam logic [SIZE_PC-1:0] LINE_BYTES = SIZE_PC'(1) << OFFSET_BITS;

  logic                   pf_fill_reg;
  logic                   pf_valid_reg;
  logic [SIZE_PC-1:0]     pf_addr_reg;
  logic [CACHE_WIDTH-1:0] pf_line_reg;

  assign pf_hit    = pf_valid_reg && (pf_addr_reg == miss_line);
  assign pf_fill   = pf_fill_reg;
  // Prefetch only when the cache is no longer missing. A still-high miss
  // after SETTLE is a new demand request and takes priority.
  assign pf_launch = (state_reg == S_SETTLE) && !miss_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pf_fill_reg  <= 1'b0;
      pf_valid_reg <= 1'b0;
      pf_addr_reg  <= '0;
      pf_line_reg  <= '0;
    end else begin
      if (pf_launch) begin
        pf_fill_reg <= 1'b1;
      end else if (last_beat && pf_fill_reg) begin
        pf_fill_reg  <= 1'b0;
        pf_valid_reg <= 1'b1;
        pf_addr_reg  <= addr_reg;
        pf_line_reg  <= line_next;
      end
      // The buffered line is consumed by the hit that uses it.
      if (capture && pf_hit) begin
        pf_valid_reg <= 1'b0;
      end
    end
  end
`else
  assign pf_hit    = 1'b0;
  assign pf_fill   = 1'b0;
  assign pf_launch = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (miss_i) begin
          state_next = pf_hit ? S_WRITE : S_REQ;
        end
      end
      S_REQ: begin
        if (memReqAck_i) begin
          state_next = S_RECV;
        end
      end
      S_RECV: begin
        // A completed prefetch goes straight back to IDLE. Nothing is
        // written to the cache, so there is no stale miss to filter.
        if (last_beat) begin
          state_next = pf_fill ? S_IDLE : S_WRITE;
        end
      end
      S_WRITE: begin
        state_next = S_SETTLE;
      end
      S_SETTLE: begin
        // miss_i is deliberately ignored here. The cache's registered lookup
        // may still show the miss we just filled.
        state_next = pf_launch ? S_REQ : S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs and internal strobes
  // -------------------------------------------------------------------------
  always_comb begin
    memReq_o   = 1'b0;
    wrEnable_o = 1'b0;
    busy_o     = 1'b1;
    capture    = 1'b0;
    beat_fire  = 1'b0;
    last_beat  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy_o  = 1'b0;
        capture = miss_i;
      end
      S_REQ: begin
        memReq_o = 1'b1;
      end
      S_RECV: begin
        // Beats outside RECV never reach the assembly buffer.
        beat_fire = memRdValid_i;
        last_beat = memRdValid_i && (cnt_reg == LAST_BEAT);
      end
      S_WRITE: begin
        wrEnable_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Beat steering. Each slot of the line takes the incoming beat only when
  // the counter points at that slot.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      assign line_next[gi*BEAT_WIDTH +: BEAT_WIDTH] =
        (beat_fire && (cnt_reg == CNT_W'(gi))) ? memRdData_i
                                               : line_reg[gi*BEAT_WIDTH +: BEAT_WIDTH];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg      <= '0;
      addr_reg     <= '0;
      line_reg     <= '0;
      wr_addr_reg  <= '0;
      wr_block_reg <= '0;
    end else begin
      // The line address is frozen from capture until IDLE is re-entered.
      // Later changes to missAddr_i do not reach the request.
      if (capture) begin
        addr_reg <= miss_line;
`ifdef ICACHE_REFILL_PREFETCH_EN
      end else if (pf_launch) begin
        addr_reg <= addr_reg + LINE_BYTES;   // wraps modulo 2^SIZE_PC
`endif
      end

      if ((state_reg == S_REQ) && memReqAck_i) begin
        cnt_reg <= '0;
      end else if (beat_fire) begin
        cnt_reg <= last_beat ? '0 : cnt_reg + 1'b1;
      end

      if (beat_fire) begin
        line_reg <= line_next;
      end

      // Load the write port on entry to WRITE. It then holds its value
      // until the next fill, so the outputs stay stable between strobes.
      if (last_beat && !pf_fill) begin
        wr_addr_reg  <= addr_reg;
        wr_block_reg <= line_next;
      end
`ifdef ICACHE_REFILL_PREFETCH_EN
      if (capture && pf_hit) begin
        wr_addr_reg  <= miss_line;
        wr_block_reg <= pf_line_reg;
      end
`endif
    end
  end

  assign memAddr_o   = addr_reg;
  assign wrAddr_o    = wr_addr_reg;
  assign instBlock_o = wr_block_reg;

endmodule

// File: tb/tb_icache_refill_unit.sv
// ---------------------------------------------------------------------------
// tb_icache_refill_unit
//
// Directed, self-checking bench for icache_refill_unit. A table of demand
// refills (address, ack delay, beat gap, beats, expected line) is replayed
// in a loop. Hand-written sequences then cover the multi-cycle corners:
// stray beats while idle, reset during RECV, and a fetch redirect during
// RECV. The next-line prefetch sequence is compiled only when
// ICACHE_REFILL_PREFETCH_EN is defined.
// ---------------------------------------------------------------------------
module tb_icache_refill_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         miss_i;
  logic [31:0]  missAddr_i;
  logic         wrEnable_o;
  logic [31:0]  wrAddr_o;
  logic [255:0] instBlock_o;
  logic         memReq_o;
  logic [31:0]  memAddr_o;
  logic         memReqAck_i;
  logic         memRdValid_i;
  logic [63:0]  memRdData_i;
  logic         busy_o;

  always #5 clk = ~clk;

  icache_refill_unit #(
    .SIZE_PC(32), .CACHE_WIDTH(256), .BEAT_WIDTH(64), .OFFSET_BITS(5)
  ) dut (
    .clk(clk), .reset(reset),
    .miss_i(miss_i), .missAddr_i(missAddr_i),
    .wrEnable_o(wrEnable_o), .wrAddr_o(wrAddr_o), .instBlock_o(instBlock_o),
    .memReq_o(memReq_o), .memAddr_o(memAddr_o), .memReqAck_i(memReqAck_i),
    .memRdValid_i(memRdValid_i), .memRdData_i(memRdData_i),
    .busy_o(busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string            name;
    logic [31:0]      miss_addr;
    int               ack_delay;
    int               gap;
    logic [3:0][63:0] beats;
    logic [31:0]      exp_addr;
    logic [255:0]     exp_block;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d);
    memRdValid_i = 1'b1;
    memRdData_i  = d;
    tick();
    memRdValid_i = 1'b0;
    memRdData_i  = '0;
  endtask

  // Called with the DUT in REQ. Holds the ack off for `delay` cycles, then
  // delivers four beats, each preceded by `gap` idle cycles.
  task automatic serve(input string tag, input int delay, input int gap,
                       input logic [3:0][63:0] beats);
    for (int d = 0; d < delay; d++) begin
      tick();
      check({tag, " req held"}, 256'(memReq_o), 256'(1));
    end
    memReqAck_i = 1'b1;
    tick();
    memReqAck_i = 1'b0;
    check({tag, " req dropped after ack"}, 256'(memReq_o), 256'(0));
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        tick();
        check({tag, " no write in gap"}, 256'(wrEnable_o), 256'(0));
      end
      beat(beats[b]);
      if (b < 3) check({tag, " no early write"}, 256'(wrEnable_o), 256'(0));
    end
  endtask

  // Runs a full demand refill. On return the DUT is in WRITE and miss_i is
  // still high.
  task automatic run_demand(input string tag, input logic [31:0] addr, input int delay,
                            input int gap, input logic [3:0][63:0] beats,
                            input logic [31:0] exp_addr, input logic [255:0] exp_block);
    missAddr_i = addr;
    miss_i     = 1'b1;
    tick();
    check({tag, " memReq"}, 256'(memReq_o), 256'(1));
    check({tag, " memAddr"}, 256'(memAddr_o), 256'(exp_addr));
    check({tag, " busy"}, 256'(busy_o), 256'(1));
    serve(tag, delay, gap, beats);
    check({tag, " wrEnable"}, 256'(wrEnable_o), 256'(1));
    check({tag, " wrAddr"}, 256'(wrAddr_o), 256'(exp_addr));
    check({tag, " instBlock"}, instBlock_o, exp_block);
    $display("refill %s: miss %h -> line %h written", tag, addr, wrAddr_o);
  endtask

  // The miss stays high into SETTLE and must not start a new request.
  task automatic settle_tail(input string tag, input logic [31:0] exp_addr);
    tick();
    check({tag, " strobe one cycle"}, 256'(wrEnable_o), 256'(0));
    check({tag, " settle no req"}, 256'(memReq_o), 256'(0));
    check({tag, " settle busy"}, 256'(busy_o), 256'(1));
    miss_i = 1'b0;
    tick();
    check({tag, " idle after settle"}, 256'(busy_o), 256'(0));
    check({tag, " stale miss ignored"}, 256'(memReq_o), 256'(0));
    check({tag, " wrAddr held"}, 256'(wrAddr_o), 256'(exp_addr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"basic", 32'h0000_1234, 0, 0,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                32'h0000_1220,
                256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111};
    vecs[1] = '{"slow", 32'h0000_ABCD, 5, 2,
                {64'h0F1E_2D3C_4B5A_6978, 64'hDEAD_BEEF_CAFE_F00D,
                 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                32'h0000_ABC0,
                256'h0F1E2D3C4B5A6978_DEADBEEFCAFEF00D_FEDCBA9876543210_0123456789ABCDEF};
    vecs[2] = '{"top", 32'hFFFF_FFFF, 1, 1,
                {64'h5A5A_5A5A_A5A5_A5A5, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001},
                32'hFFFF_FFE0,
                256'h5A5A5A5AA5A5A5A5_FFFFFFFFFFFFFFFF_8000000000000000_0000000000000001};

    reset = 1'b1; miss_i = 1'b0; missAddr_i = '0;
    memReqAck_i = 1'b0; memRdValid_i = 1'b0; memRdData_i = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset busy", 256'(busy_o), 256'(0));
    check("reset memReq", 256'(memReq_o), 256'(0));
    check("reset wrEnable", 256'(wrEnable_o), 256'(0));
    check("reset memAddr", 256'(memAddr_o), 256'(0));
    check("reset wrAddr", 256'(wrAddr_o), 256'(0));
    check("reset instBlock", instBlock_o, 256'(0));

    // Table-driven demand refills
    for (int i = 0; i < 3; i++) begin
      run_demand(vecs[i].name, vecs[i].miss_addr, vecs[i].ack_delay, vecs[i].gap,
                 vecs[i].beats, vecs[i].exp_addr, vecs[i].exp_block);
      settle_tail(vecs[i].name, vecs[i].exp_addr);
    end

    // Stray beats while IDLE must not move the counter or cause a write.
    memRdValid_i = 1'b1;
    memRdData_i  = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stray beat no write", 256'(wrEnable_o), 256'(0));
      check("stray beat idle", 256'(busy_o), 256'(0));
    end
    memRdValid_i = 1'b0;
    memRdData_i  = '0;
    $display("stray beats while idle: 3 cycles");
    run_demand("after stray", 32'h0000_2010, 0, 0,
               {64'hD3D3_D3D3_D3D3_D3D3, 64'hC2C2_C2C2_C2C2_C2C2,
                64'hB1B1_B1B1_B1B1_B1B1, 64'hA0A0_A0A0_A0A0_A0A0},
               32'h0000_2000,
               256'hD3D3D3D3D3D3D3D3_C2C2C2C2C2C2C2C2_B1B1B1B1B1B1B1B1_A0A0A0A0A0A0A0A0);
    settle_tail("after stray", 32'h0000_2000);

    // Reset during RECV after two beats, with a third beat in flight.
    missAddr_i = 32'h0000_1234;
    miss_i     = 1'b1;
    tick();
    memReqAck_i = 1'b1;
    tick();
    memReqAck_i = 1'b0;
    beat(64'h1111_1111_1111_1111);
    beat(64'h2222_2222_2222_2222);
    memRdValid_i = 1'b1;
    memRdData_i  = 64'h3333_3333_3333_3333;
    reset = 1'b1;
    #1;
    check("async reset busy", 256'(busy_o), 256'(0));
    check("async reset memReq", 256'(memReq_o), 256'(0));
    check("async reset memAddr", 256'(memAddr_o), 256'(0));
    check("async reset wrAddr", 256'(wrAddr_o), 256'(0));
    check("async reset instBlock", instBlock_o, 256'(0));
    memRdValid_i = 1'b0;
    memRdData_i  = '0;
    miss_i       = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post reset no write", 256'(wrEnable_o), 256'(0));
    $display("reset during RECV after 2 beats");
    run_demand("after reset", 32'h0000_0040, 0, 0,
               {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001},
               32'h0000_0040,
               256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001);
    settle_tail("after reset", 32'h0000_0040);

    // Fetch redirect during RECV: the fill still completes to the old line.
    missAddr_i = 32'h0000_1234;
    miss_i     = 1'b1;
    tick();
    check("redirect memAddr", 256'(memAddr_o), 256'(32'h0000_1220));
    memReqAck_i = 1'b1;
    tick();
    memReqAck_i = 1'b0;
    beat(64'hAAAA_0000_0000_0001);
    beat(64'hAAAA_0000_0000_0002);
    miss_i     = 1'b0;
    missAddr_i = 32'h0000_9000;
    beat(64'hAAAA_0000_0000_0003);
    beat(64'hAAAA_0000_0000_0004);
    check("redirect wrEnable", 256'(wrEnable_o), 256'(1));
    check("redirect wrAddr", 256'(wrAddr_o), 256'(32'h0000_1220));
    check("redirect instBlock", instBlock_o,
          256'hAAAA000000000004_AAAA000000000003_AAAA000000000002_AAAA000000000001);
    $display("redirect during RECV: line %h written", wrAddr_o);
    tick();
    check("redirect settle no req", 256'(memReq_o), 256'(0));
    check("redirect strobe one cycle", 256'(wrEnable_o), 256'(0));

`ifdef ICACHE_REFILL_PREFETCH_EN
    // SETTLE with no miss starts a next-line prefetch.
    tick();
    check("prefetch req", 256'(memReq_o), 256'(1));
    check("prefetch addr", 256'(memAddr_o), 256'(32'h0000_1240));
    serve("prefetch 1240", 0, 0,
          {64'hBBBB_0000_0000_0004, 64'hBBBB_0000_0000_0003,
           64'hBBBB_0000_0000_0002, 64'hBBBB_0000_0000_0001});
    check("prefetch no cache write", 256'(wrEnable_o), 256'(0));
    check("prefetch back to idle", 256'(busy_o), 256'(0));
    check("prefetch wrAddr held", 256'(wrAddr_o), 256'(32'h0000_1220));
    $display("prefetch: line 00001240 buffered");
    missAddr_i = 32'h0000_1248;
    miss_i     = 1'b1;
    tick();
    check("pf hit wrEnable", 256'(wrEnable_o), 256'(1));
    check("pf hit no memReq", 256'(memReq_o), 256'(0));
    check("pf hit wrAddr", 256'(wrAddr_o), 256'(32'h0000_1240));
    check("pf hit instBlock", instBlock_o,
          256'hBBBB000000000004_BBBB000000000003_BBBB000000000002_BBBB000000000001);
    $display("prefetch hit: miss 00001248 -> line %h written", wrAddr_o);
    miss_i = 1'b0;
    tick();
    tick();
    check("next prefetch addr", 256'(memAddr_o), 256'(32'h0000_1260));
    serve("prefetch 1260", 0, 0, {64'h4, 64'h3, 64'h2, 64'h1});
    check("prefetch 1260 idle", 256'(busy_o), 256'(0));
    run_demand("wrap", 32'hFFFF_FFE0, 0, 0,
               {64'h0D, 64'h0C, 64'h0B, 64'h0A}, 32'hFFFF_FFE0,
               256'h000000000000000D_000000000000000C_000000000000000B_000000000000000A);
    miss_i = 1'b0;
    tick();
    tick();
    check("wrap prefetch req", 256'(memReq_o), 256'(1));
    check("wrap prefetch addr", 256'(memAddr_o), 256'(0));
    serve("prefetch wrap", 0, 0, {64'h8, 64'h7, 64'h6, 64'h5});
    check("prefetch wrap idle", 256'(busy_o), 256'(0));
    $display("prefetch wrap: FFFFFFE0 -> 00000000");
`else
    for (int i = 0; i < 3; i++) begin
      tick();
      check("redirect no second req", 256'(memReq_o), 256'(0));
    end
    check("redirect idle", 256'(busy_o), 256'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
